// File: rtl/axi_rd_pkg.sv
// Shared AXI4 read-channel constants and the line-reader FSM state type.
package axi_rd_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rd_state_e;

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beats for the next burst: smallest of words left in the line, MAX_BURST,
// and the words remaining before the next 4 KB boundary.
module axi_burst_len_calc #(
  parameter int MAX_BURST = 16,
  parameter int LINE_W    = 12
) (
  input  logic [11:0]       addr_lo,
  input  logic [LINE_W-1:0] words_left,
  output logic [8:0]        beats
);

  logic [12:0] room_bytes;
  logic [31:0] room_words;
  logic [31:0] best;

  always_comb begin
    room_bytes = 13'd4096 - {1'b0, addr_lo};
    room_words = 32'(room_bytes[12:2]);
    best       = 32'(words_left);
    if (room_words < best) best = room_words;
    if (32'(MAX_BURST) < best) best = 32'(MAX_BURST);
    beats = best[8:0];
  end

endmodule

// File: rtl/axi_line_rd_master.sv
// AXI4 read initiator fetching a rectangular region line by line and
// streaming it out. Optional rresp/rlast checking: define AXI_RD_RESP_CHK_EN.
module axi_line_rd_master
  import axi_rd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LINE_W    = 12
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LINE_W-1:0] line_words,
  input  logic [LINE_W-1:0] num_lines,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready
);

  rd_state_e         state;
  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] next_line;
  logic [LINE_W-1:0] words_left;
  logic [LINE_W-1:0] lines_left;
  logic [LINE_W-1:0] line_words_q;
  logic [8:0]        beats;
  logic [8:0]        beats_q;
  logic [8:0]        beat_cnt;
  logic              in_data;
  logic              r_hs;
  logic              burst_end;
  logic              beat_err;

  axi_burst_len_calc #(
    .MAX_BURST (MAX_BURST),
    .LINE_W    (LINE_W)
  ) u_len (
    .addr_lo    (cur_addr[11:0]),
    .words_left (words_left),
    .beats      (beats)
  );

  // AR is driven straight from registered state, so it is stable until arready.
  assign arvalid   = (state == ADDR);
  assign araddr    = cur_addr;
  assign arlen     = arvalid ? (beats[7:0] - 8'd1) : 8'd0;
  assign arsize    = AXI_SIZE_4B;
  assign arburst   = AXI_BURST_INCR;

  assign in_data   = (state == DATA);
  assign rready    = in_data & m_tready;
  assign m_tvalid  = in_data & rvalid;
  assign m_tdata   = rdata;
  assign m_tlast   = m_tvalid & (words_left == LINE_W'(1));
  assign r_hs      = in_data & rvalid & m_tready;
  assign next_line = line_addr + stride_q;

`ifdef AXI_RD_RESP_CHK_EN
  assign beat_err  = (rresp != AXI_RESP_OKAY) || (rlast != (beat_cnt == 9'd1));
  assign burst_end = rlast || (beat_cnt == 9'd1);
`else
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast};
  assign beat_err    = 1'b0;
  assign burst_end   = (beat_cnt == 9'd1);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      line_addr    <= '0;
      cur_addr     <= '0;
      stride_q     <= '0;
      words_left   <= '0;
      lines_left   <= '0;
      line_words_q <= '0;
      beats_q      <= '0;
      beat_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // A zero-size frame reaches DONE still busy; its done pulse is issued here.
          if (state == DONE && busy) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (start) begin
            line_addr    <= {base_addr[ADDR_W-1:2], 2'b00};
            cur_addr     <= {base_addr[ADDR_W-1:2], 2'b00};
            stride_q     <= {stride[ADDR_W-1:2], 2'b00};
            line_words_q <= line_words;
            words_left   <= line_words;
            lines_left   <= num_lines;
            err          <= 1'b0;
            busy         <= 1'b1;
            state        <= (line_words == '0 || num_lines == '0) ? DONE : ADDR;
          end else begin
            state <= IDLE;
          end
        end
        ADDR: begin
          if (arready) begin
            beats_q  <= beats;
            beat_cnt <= beats;
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt   <= beat_cnt - 9'd1;
            words_left <= words_left - LINE_W'(1);
            if (beat_err) err <= 1'b1;
            if (burst_end) begin
              if (err || beat_err) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end else if (words_left != LINE_W'(1)) begin
                cur_addr <= cur_addr + ADDR_W'({beats_q, 2'b00});
                state    <= ADDR;
              end else begin
                line_addr  <= next_line;
                cur_addr   <= next_line;
                words_left <= line_words_q;
                lines_left <= lines_left - LINE_W'(1);
                if (lines_left != LINE_W'(1)) begin
                  state <= ADDR;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_line_rd_master.sv
// Bench for axi_line_rd_master: AXI slave model, stream scoreboard and timing checks.
module tb_axi_line_rd_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [31:0] stride = '0;
  logic [11:0] line_words = '0;
  logic [11:0] num_lines = '0;
  logic        busy, done, err;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;

  axi_line_rd_master #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(16), .LINE_W(12)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .stride(stride), .line_words(line_words), .num_lines(num_lines),
    .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rlast_cyc = 0;
  int done_cnt = 0;
  int gbeat = 0;
  int err_beat = -1;
  logic first_ar_pend = 1'b0;
  logic rlast_seen = 1'b0;
  logic zero_frame = 1'b0;
  logic tready_toggle = 1'b0;

  ar_t         exp_ar[$];
  logic [32:0] exp_beats[$];
  ar_t         bursts[$];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk_reset();
    chk("rst_busy",    64'(busy),     64'(0));
    chk("rst_done",    64'(done),     64'(0));
    chk("rst_err",     64'(err),      64'(0));
    chk("rst_arvalid", 64'(arvalid),  64'(0));
    chk("rst_araddr",  64'(araddr),   64'(0));
    chk("rst_arlen",   64'(arlen),    64'(0));
    chk("rst_arsize",  64'(arsize),   64'(2));
    chk("rst_arburst", 64'(arburst),  64'(1));
    chk("rst_rready",  64'(rready),   64'(0));
    chk("rst_tvalid",  64'(m_tvalid), 64'(0));
    chk("rst_tlast",   64'(m_tlast),  64'(0));
    chk("rst_tdata",   64'(m_tdata),  64'(rdata));
  endtask

  // AXI slave model and output monitor: drive at negedge, sample 1 time unit later
  initial begin
    int   beat;
    logic ar_hs, r_hs, r_last_cap, arv_prev;
    ar_t  ar_cap, e;
    logic [32:0] eb;
    beat = 0; ar_hs = 0; r_hs = 0; r_last_cap = 0; arv_prev = 0; ar_cap = '0;
    forever begin
      @(negedge aclk);
      if (ar_hs) bursts.push_back(ar_cap);
      if (r_hs) begin
        beat++;
        gbeat++;
        if (r_last_cap && bursts.size() > 0) begin
          void'(bursts.pop_front());
          beat = 0;
        end
      end
      arready = ($urandom_range(0, 3) != 0);
      m_tready = tready_toggle ? ~m_tready : 1'b1;
      if (bursts.size() > 0 && aresetn) begin
        rvalid = 1'b1;
        rdata  = mem_word(bursts[0].addr + 32'(beat) * 32'd4);
        rlast  = (beat == 32'(bursts[0].len));
        rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rdata  = $urandom;
      end
      #1;
      if (!aresetn) begin
        bursts.delete();
        beat = 0; ar_hs = 0; r_hs = 0; arv_prev = 0;
        continue;
      end
      ar_hs      = arvalid && arready;
      r_hs       = rvalid && rready;
      r_last_cap = rlast;
      ar_cap     = '{addr: araddr, len: arlen};
      if (arvalid && !arv_prev) begin
        if (first_ar_pend) begin
          chk("ar_latency", 64'(cyc - start_cyc), 64'(1));
          first_ar_pend = 1'b0;
        end else if (rlast_seen) begin
          chk("rlast_to_ar", 64'(cyc - rlast_cyc), 64'(1));
        end
      end
      arv_prev = arvalid;
      if (ar_hs) begin
        if (exp_ar.size() == 0) begin
          chk("ar_unexpected", 64'(araddr), 64'(0));
        end else begin
          e = exp_ar.pop_front();
          chk("araddr", 64'(araddr), 64'(e.addr));
          chk("arlen", 64'(arlen), 64'(e.len));
          chk("arsize", 64'(arsize), 64'(2));
          chk("arburst", 64'(arburst), 64'(1));
        end
      end
      if (rvalid) chk("rready_mirror", 64'(rready), 64'(m_tready));
      if (m_tvalid && m_tready) begin
        if (exp_beats.size() == 0) begin
          chk("beat_unexpected", 64'(m_tdata), 64'(0));
        end else begin
          eb = exp_beats.pop_front();
          chk("tdata", 64'(m_tdata), 64'(eb[31:0]));
          chk("tlast", 64'(m_tlast), 64'(eb[32]));
        end
      end
      if (r_hs && rlast) begin
        rlast_cyc  = cyc;
        rlast_seen = 1'b1;
      end
      if (done) begin
        done_cnt++;
        chk("done_busy", 64'(busy), 64'(0));
        if (zero_frame) chk("done_lat_zero", 64'(cyc - start_cyc), 64'(2));
        else            chk("done_lat", 64'(cyc - rlast_cyc), 64'(1));
      end
    end
  end

  task automatic run_frame(input logic [31:0] b, input logic [31:0] s,
                           input int lw, input int nl, input logic toggle,
                           input logic dup, input int exp_lines, input logic exp_err);
    logic [31:0] a;
    int d0;
    for (int l = 0; l < exp_lines; l++)
      for (int w = 0; w < lw; w++) begin
        a = {b[31:2], 2'b00} + 32'(l) * {s[31:2], 2'b00} + 32'(w) * 32'd4;
        exp_beats.push_back({(w == lw - 1), mem_word(a)});
      end
    zero_frame    = (lw == 0 || nl == 0);
    first_ar_pend = !zero_frame;
    rlast_seen    = 1'b0;
    gbeat         = 0;
    tready_toggle = toggle;
    d0 = done_cnt;
    @(negedge aclk);
    base_addr = b; stride = s; line_words = 12'(lw); num_lines = 12'(nl);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge aclk);
    start = 1'b0;
    chk("busy_on", 64'(busy), 64'(1));
    chk("err_clr", 64'(err), 64'(0));
    if (dup) begin
      repeat (3) @(negedge aclk);
      base_addr = 32'h9000; line_words = 12'd1; num_lines = 12'd1;
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge aclk);
    chk("done_seen", 64'(done_cnt - d0), 64'(1));
    repeat (2) @(negedge aclk);
    chk("done_single", 64'(done_cnt - d0), 64'(1));
    chk("ar_left", 64'(exp_ar.size()), 64'(0));
    chk("beats_left", 64'(exp_beats.size()), 64'(0));
    chk("err_end", 64'(err), 64'(exp_err));
    chk("busy_off", 64'(busy), 64'(0));
    exp_ar.delete();
    exp_beats.delete();
    tready_toggle = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge aclk);
    chk_reset();
    aresetn = 1'b1;
    @(negedge aclk);

    exp_ar.push_back('{32'h1000, 8'd3});
    run_frame(32'h1000, 32'h40, 4, 1, 1'b0, 1'b0, 1, 1'b0);

    exp_ar.push_back('{32'h5000, 8'd1});
    run_frame(32'h5002, 32'h43, 2, 1, 1'b0, 1'b0, 1, 1'b0);

    exp_ar.push_back('{32'h0000, 8'd15});
    exp_ar.push_back('{32'h0040, 8'd15});
    exp_ar.push_back('{32'h0080, 8'd7});
    run_frame(32'h0, 32'h0, 40, 1, 1'b0, 1'b0, 1, 1'b0);

    exp_ar.push_back('{32'h0FF8, 8'd1});
    exp_ar.push_back('{32'h1000, 8'd5});
    run_frame(32'h0FF8, 32'h40, 8, 1, 1'b0, 1'b0, 1, 1'b0);

    exp_ar.push_back('{32'h2000, 8'd2});
    exp_ar.push_back('{32'h2100, 8'd2});
    exp_ar.push_back('{32'h2200, 8'd2});
    run_frame(32'h2000, 32'h100, 3, 3, 1'b0, 1'b1, 3, 1'b0);

    exp_ar.push_back('{32'h4000, 8'd15});
    run_frame(32'h4000, 32'h40, 16, 1, 1'b1, 1'b0, 1, 1'b0);

    run_frame(32'h7000, 32'h10, 5, 0, 1'b0, 1'b0, 0, 1'b0);
    run_frame(32'h7000, 32'h10, 0, 2, 1'b0, 1'b0, 0, 1'b0);

    err_beat = 1;
`ifdef AXI_RD_RESP_CHK_EN
    exp_ar.push_back('{32'h3000, 8'd3});
    run_frame(32'h3000, 32'h100, 4, 2, 1'b0, 1'b0, 1, 1'b1);
`else
    exp_ar.push_back('{32'h3000, 8'd3});
    exp_ar.push_back('{32'h3100, 8'd3});
    run_frame(32'h3000, 32'h100, 4, 2, 1'b0, 1'b0, 2, 1'b0);
`endif
    err_beat = -1;

    exp_ar.push_back('{32'h1000, 8'd3});
    run_frame(32'h1000, 32'h40, 4, 1, 1'b0, 1'b0, 1, 1'b0);

    // Reset in the middle of a burst
    exp_ar.push_back('{32'h6000, 8'd15});
    for (int w = 0; w < 16; w++)
      exp_beats.push_back({(w == 15), mem_word(32'h6000 + 32'(w) * 32'd4)});
    zero_frame = 1'b0; first_ar_pend = 1'b1; rlast_seen = 1'b0; gbeat = 0;
    @(negedge aclk);
    base_addr = 32'h6000; stride = 32'h40; line_words = 12'd16; num_lines = 12'd1;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge aclk);
    start = 1'b0;
    for (int i = 0; i < 500 && exp_beats.size() > 12; i++) @(negedge aclk);
    chk("mid_burst_reached", 64'(exp_beats.size() <= 12), 64'(1));
    chk("mid_busy", 64'(busy), 64'(1));
    aresetn = 1'b0;
    #2;
    chk_reset();
    repeat (2) @(negedge aclk);
    exp_ar.delete();
    exp_beats.delete();
    first_ar_pend = 1'b0;
    aresetn = 1'b1;
    @(negedge aclk);

    exp_ar.push_back('{32'h2000, 8'd2});
    exp_ar.push_back('{32'h2100, 8'd2});
    run_frame(32'h2000, 32'h100, 3, 2, 1'b0, 1'b0, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
